serial_tx_piso: RTL

Parallel-in, serial-out transmitter that serialises a WIDTH-bit word onto a single line as a framed bit stream: start bit, data LSB-first, stop bit. It is the sending end of the registered serial link in the lab designs. A producer hands it a word through a Valid/Ready handshake, and it drives the line TxOut. All state is in Clock-edge flip-flops with the same synchronous active-low reset style as the rest of the storage elements.

---
 rtl/serial_tx_piso_if.sv | 27 ++
 rtl/serial_tx_piso.sv | 118 +++++++++++
 2 files changed

// File: rtl/serial_tx_piso_if.sv
// Producer-side handshake and serial line of the framed PISO transmitter.
// The master drives the word and Valid; the slave (transmitter) returns Ready, Busy and the line.
interface serial_tx_piso_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] Data;
   logic             Valid;
   logic             Ready;
   logic             TxOut;
   logic             Busy;

   modport master (
      output Data,
      output Valid,
      input  Ready,
      input  TxOut,
      input  Busy
   );

   modport slave (
      input  Data,
      input  Valid,
      output Ready,
      output TxOut,
      output Busy
   );
endinterface

// File: rtl/serial_tx_piso.sv
// Framed parallel-in serial-out transmitter: start bit, WIDTH data bits LSB-first, stop bit,
// each held CLKS_PER_BIT cycles. All outputs are registered; synchronous active-low reset.
module serial_tx_piso #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   serial_tx_piso_if.slave   tx
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BitW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic              tx_q, tx_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              wrap;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // With CLKS_PER_BIT=1 CntMax is 0, so every cycle wraps and cnt stays at 0.
   assign wrap = (cnt_q == CntMax);

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;

      unique case (state_q)
         StIdle: begin
            if (tx.Valid) begin
               shreg_d = tx.Data;
               cnt_d   = '0;
               bit_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (wrap) begin
               cnt_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StData: begin
            if (wrap) begin
               cnt_d   = '0;
               shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
               if (bit_q == LastBit) begin
                  bit_d   = '0;
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StStop: begin
            if (wrap) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so the registered line tracks the state exactly.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         StIdle:  tx_d = 1'b1;
         StStart: tx_d = 1'b0;
         StData:  tx_d = shreg_d[0];
         StStop:  tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
      ready_d = (state_d == StIdle);
      busy_d  = ~ready_d;
   end

   assign tx.TxOut = tx_q;
   assign tx.Ready = ready_q;
   assign tx.Busy  = busy_q;

endmodule
